// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, FIFO entry layout and
// oversampling constant, reused by the receive and transmit channels.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    typedef struct packed {
        logic       fe;
        logic       pe;
        logic [7:0] data;
    } rx_entry_t;

    // Parity error: received ones count (data plus parity bit) disagrees with the selected sense
    function automatic logic parity_error(input logic [7:0] data, input logic par_bit, input logic odd);
        return ((^data) ^ par_bit) != odd;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive holding FIFO of status-tagged entries; a push while full
// is accepted only when a pop frees the head slot in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  rx_entry_t wr_entry,
    output rx_entry_t head,
    output logic      empty,
    output logic      full
);

    localparam int AW = $clog2(DEPTH);

    rx_entry_t     mem_r [DEPTH];
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic          do_pop_s;
    logic          do_push_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Read/write pointers, one extra wrap bit to tell full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Entry storage; contents are only visible through the empty-gated head
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_entry;
        end
    end

    // Head entry, forced to zero while empty
    always_comb begin
        head = '0;
        if (empty) begin
            head = '0;
        end else begin
            head = mem_r[rd_ptr_r[AW-1:0]];
        end
    end

endmodule

// File: rtl/uart_rx_channel.sv
// Configurable-width, configurable-parity UART receiver with 16x oversampling,
// feeding a status-tagged receive FIFO with sticky overrun detection.
module uart_rx_channel
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 _RESET,
    input  logic                 BAUD_X16,
    input  logic                 RXD,
    input  logic                 RX_EN,
    input  logic                 PARITY_EN,
    input  logic                 PARITY_ODD,
    input  logic                 RD_STB,
    input  logic                 CLR_ERR,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_PE,
    output logic                 RX_FE,
    output logic                 RXRDY,
    output logic                 FFULL,
    output logic                 OVERRUN
);

    localparam logic [3:0] MID_CNT  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST_CNT = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic                 rxd_meta_r, rxd_sync_r;
    rx_state_t            state_r, state_s;
    logic [3:0]           cnt_r, cnt_s;
    logic [2:0]           idx_r, idx_s;
    logic [DATA_BITS-1:0] shift_r, shift_s;
    logic                 pe_r, pe_s;
    logic                 brk_r, brk_s;
    logic                 push_s, fe_s;
    logic                 empty_s, full_s;
    logic                 overrun_r;
    rx_entry_t            entry_s, head_s;

    // Two-flop synchroniser; resets to the idle line level
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
        end else begin
            rxd_meta_r <= RXD;
            rxd_sync_r <= rxd_meta_r;
        end
    end

    // Receiver state, tick counter, bit index, shift register and flags
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            idx_r   <= 3'd0;
            shift_r <= '0;
            pe_r    <= 1'b0;
            brk_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            shift_r <= shift_s;
            pe_r    <= pe_s;
            brk_r   <= brk_s;
        end
    end

    // Next-state logic; all sampling happens only on oversampling ticks
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        shift_s = shift_r;
        pe_s    = pe_r;
        brk_s   = brk_r;
        push_s  = 1'b0;
        fe_s    = 1'b0;
        if (!RX_EN) begin
            state_s = IDLE;
            cnt_s   = 4'd0;
            brk_s   = 1'b0;
        end else if (BAUD_X16) begin
            cnt_s = cnt_r + 4'd1;
            case (state_r)
                IDLE: begin
                    cnt_s = 4'd0;
                    if (!rxd_sync_r) begin
                        state_s = START;
                        pe_s    = 1'b0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                START: begin
                    if (cnt_r == MID_CNT) begin
                        cnt_s   = 4'd0;
                        idx_s   = 3'd0;
                        state_s = rxd_sync_r ? IDLE : DATA;
                    end else begin
                        state_s = START;
                    end
                end
                DATA: begin
                    if (cnt_r == LAST_CNT) begin
                        shift_s = {rxd_sync_r, shift_r[DATA_BITS-1:1]};
                        idx_s   = idx_r + 3'd1;
                        if (idx_r == LAST_BIT) begin
                            state_s = PARITY_EN ? PARITY : STOP;
                        end else begin
                            state_s = DATA;
                        end
                    end else begin
                        state_s = DATA;
                    end
                end
                PARITY: begin
                    if (cnt_r == LAST_CNT) begin
                        pe_s    = parity_error(8'(shift_r), rxd_sync_r, PARITY_ODD);
                        state_s = STOP;
                    end else begin
                        state_s = PARITY;
                    end
                end
                STOP: begin
                    // After a framing error, hold here until the line returns high
                    if (brk_r) begin
                        cnt_s = 4'd0;
                        if (rxd_sync_r) begin
                            state_s = IDLE;
                            brk_s   = 1'b0;
                        end else begin
                            state_s = STOP;
                        end
                    end else if (cnt_r == LAST_CNT) begin
                        push_s  = 1'b1;
                        fe_s    = ~rxd_sync_r;
                        brk_s   = ~rxd_sync_r;
                        state_s = rxd_sync_r ? IDLE : STOP;
                    end else begin
                        state_s = STOP;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = 4'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    assign entry_s = '{fe: fe_s, pe: pe_r, data: 8'(shift_r)};

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst_n    (_RESET),
        .push     (push_s),
        .pop      (RD_STB),
        .wr_entry (entry_s),
        .head     (head_s),
        .empty    (empty_s),
        .full     (full_s)
    );

    // Sticky overrun: a lost character outranks a simultaneous clear
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            overrun_r <= 1'b0;
        end else if (push_s && full_s && !RD_STB) begin
            overrun_r <= 1'b1;
        end else if (CLR_ERR) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign RX_DATA = head_s.data[DATA_BITS-1:0];
    assign RX_PE   = head_s.pe;
    assign RX_FE   = head_s.fe;
    assign RXRDY   = ~empty_s;
    assign FFULL   = full_s;
    assign OVERRUN = overrun_r;

endmodule

// File: tb/tb_uart_rx_channel.sv
// Directed bench for uart_rx_channel: an 8-bit/no-parity instance and a
// 7-bit instance for parity, driven with serial frames at 64 clocks per bit.
module tb_uart_rx_channel;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       baud = 1'b0;
    logic       rxd8 = 1'b1;
    logic       rxd7 = 1'b1;
    logic       rx_en = 1'b1;
    logic       par_en = 1'b0;
    logic       par_odd = 1'b0;
    logic       rd_stb = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] d8;
    logic [6:0] d7;
    logic       pe8, fe8, rdy8, full8, ovr8;
    logic       pe7, fe7, rdy7, full7, ovr7;
    int         total = 0;
    int         bad = 0;
    bit         found;

    uart_rx_channel #(.DATA_BITS(8), .FIFO_DEPTH(4)) dut8 (
        .CLK(clk), ._RESET(reset_n), .BAUD_X16(baud), .RXD(rxd8), .RX_EN(rx_en),
        .PARITY_EN(par_en), .PARITY_ODD(par_odd), .RD_STB(rd_stb), .CLR_ERR(clr_err),
        .RX_DATA(d8), .RX_PE(pe8), .RX_FE(fe8), .RXRDY(rdy8), .FFULL(full8), .OVERRUN(ovr8)
    );

    uart_rx_channel #(.DATA_BITS(7), .FIFO_DEPTH(4)) dut7 (
        .CLK(clk), ._RESET(reset_n), .BAUD_X16(baud), .RXD(rxd7), .RX_EN(rx_en),
        .PARITY_EN(par_en), .PARITY_ODD(par_odd), .RD_STB(rd_stb), .CLR_ERR(clr_err),
        .RX_DATA(d7), .RX_PE(pe7), .RX_FE(fe7), .RXRDY(rdy7), .FFULL(full7), .OVERRUN(ovr7)
    );

    always #5 clk = ~clk;

    // Tick every fourth clock
    initial begin
        forever begin
            repeat (3) @(negedge clk);
            baud = 1'b1;
            @(negedge clk);
            baud = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit to7, input logic v, input int nbits);
        if (to7) rxd7 = v;
        else rxd8 = v;
        repeat (64 * nbits) @(negedge clk);
    endtask

    task automatic send(input bit to7, input int nbits, input logic [7:0] d,
                        input bit pen, input bit pbit, input int stop_low);
        drive(to7, 1'b0, 1);
        for (int i = 0; i < nbits; i++) drive(to7, d[i], 1);
        if (pen) drive(to7, pbit, 1);
        if (stop_low > 0) begin
            drive(to7, 1'b0, stop_low);
            drive(to7, 1'b1, 2);
        end else begin
            drive(to7, 1'b1, 1);
        end
    endtask

    task automatic pop();
        @(negedge clk);
        rd_stb = 1'b1;
        @(negedge clk);
        rd_stb = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rxrdy", 32'(rdy8), 32'd0);
        chk("rst_ffull", 32'(full8), 32'd0);
        chk("rst_overrun", 32'(ovr8), 32'd0);
        chk("rst_data", 32'(d8), 32'd0);
        chk("rst_pe_fe", {30'd0, pe8, fe8}, 32'd0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // 8N1 0xA5
        send(1'b0, 8, 8'hA5, 1'b0, 1'b0, 0);
        chk("a5_rxrdy", 32'(rdy8), 32'd1);
        chk("a5_data", 32'(d8), 32'hA5);
        chk("a5_pe_fe", {30'd0, pe8, fe8}, 32'd0);
        pop();
        chk("a5_pop_rxrdy", 32'(rdy8), 32'd0);
        chk("a5_pop_data", 32'(d8), 32'd0);

        // 7 data bits, odd parity
        par_en = 1'b1;
        par_odd = 1'b1;
        send(1'b1, 7, 8'h41, 1'b1, 1'b1, 0);
        chk("p7_good_data", 32'(d7), 32'h41);
        chk("p7_good_pe", 32'(pe7), 32'd0);
        pop();
        send(1'b1, 7, 8'h41, 1'b1, 1'b0, 0);
        chk("p7_bad_rxrdy", 32'(rdy7), 32'd1);
        chk("p7_bad_data", 32'(d7), 32'h41);
        chk("p7_bad_pe", 32'(pe7), 32'd1);
        pop();
        chk("p7_pop_rxrdy", 32'(rdy7), 32'd0);
        par_en = 1'b0;
        par_odd = 1'b0;

        // False start: 4-tick low glitch
        rxd8 = 1'b0;
        repeat (16) @(negedge clk);
        rxd8 = 1'b1;
        repeat (200) @(negedge clk);
        chk("glitch_rxrdy", 32'(rdy8), 32'd0);
        chk("glitch_state", 32'(dut8.state_r), 32'(IDLE));

        // Stop bit held low for 3 bit times
        send(1'b0, 8, 8'h55, 1'b0, 1'b0, 3);
        chk("brk_data", 32'(d8), 32'h55);
        chk("brk_fe", 32'(fe8), 32'd1);
        chk("brk_pe", 32'(pe8), 32'd0);
        pop();
        chk("brk_single_push", 32'(rdy8), 32'd0);
        send(1'b0, 8, 8'h3C, 1'b0, 1'b0, 0);
        chk("after_brk_data", 32'(d8), 32'h3C);
        chk("after_brk_fe", 32'(fe8), 32'd0);
        pop();

        // Five characters, no reads: overrun
        for (int i = 1; i <= 5; i++) begin
            send(1'b0, 8, 8'(i), 1'b0, 1'b0, 0);
            if (i == 4) chk("fill_ffull4", 32'(full8), 32'd1);
            if (i == 4) chk("fill_overrun4", 32'(ovr8), 32'd0);
        end
        chk("ovr_ffull", 32'(full8), 32'd1);
        chk("ovr_flag", 32'(ovr8), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("ovr_read", 32'(d8), 32'(i));
            pop();
            chk("ovr_ffull_after_pop", 32'(full8), 32'd0);
        end
        chk("ovr_drained", 32'(rdy8), 32'd0);
        chk("ovr_sticky", 32'(ovr8), 32'd1);
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("clr_err", 32'(ovr8), 32'd0);

        // Full FIFO, pop on the push cycle of a fifth character
        for (int i = 1; i <= 4; i++) send(1'b0, 8, 8'(i), 1'b0, 1'b0, 0);
        found = 1'b0;
        fork
            send(1'b0, 8, 8'h05, 1'b0, 1'b0, 0);
            begin
                for (int i = 0; i < 1000 && !found; i++) begin
                    @(negedge clk);
                    #1;
                    if (dut8.push_s) begin
                        rd_stb = 1'b1;
                        found = 1'b1;
                        @(negedge clk);
                        rd_stb = 1'b0;
                    end
                end
            end
        join
        chk("simul_push_seen", 32'(found), 32'd1);
        chk("simul_overrun", 32'(ovr8), 32'd0);
        chk("simul_ffull", 32'(full8), 32'd1);
        for (int i = 2; i <= 5; i++) begin
            chk("simul_read", 32'(d8), 32'(i));
            pop();
        end
        chk("simul_drained", 32'(rdy8), 32'd0);

        // Reset mid-character
        send(1'b0, 8, 8'h77, 1'b0, 1'b0, 0);
        chk("pre_rst_data", 32'(d8), 32'h77);
        fork
            send(1'b0, 8, 8'h12, 1'b0, 1'b0, 0);
            begin
                repeat (300) @(negedge clk);
                reset_n = 1'b0;
                #1;
                chk("midrst_rxrdy", 32'(rdy8), 32'd0);
                chk("midrst_data", 32'(d8), 32'd0);
                chk("midrst_flags", {29'd0, pe8, fe8, full8}, 32'd0);
                chk("midrst_state", 32'(dut8.state_r), 32'(IDLE));
            end
        join
        reset_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("post_rst_rxrdy", 32'(rdy8), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_channel.md
# uart_rx_channel

Parametrised receive channel for the next-generation MC68681-compatible DUART core. It replaces the fixed 8N1 receive path with a configurable-width, configurable-parity receiver. Behind it sits a status-tagged receive FIFO of parametrised depth. The bus/register decode instantiates one `uart_rx_channel` per channel, so channel count scales by instantiation.

## Interface
Parameters:
- `DATA_BITS`, default 8: character width. Legal values are 5..8.
- `FIFO_DEPTH`, default 4: number of receive holding entries. Must be a power of two, at least 2.

Ports:
- `CLK`, input, 1: system clock. This is the only clock.
- `_RESET`, input, 1: asynchronous, active-low reset.
- `BAUD_X16`, input, 1: one-`CLK`-wide enable pulse at 16× the bit rate.
- `RXD`, input, 1: serial line. Asynchronous to `CLK`; idles high.
- `RX_EN`, input, 1: receiver enable. When low, the state machine is held in IDLE; the FIFO is kept.
- `PARITY_EN`, input, 1: a parity bit follows the data bits.
- `PARITY_ODD`, input, 1: 1 selects odd parity, 0 selects even.
- `RD_STB`, input, 1: one-cycle pop of the FIFO head.
- `CLR_ERR`, input, 1: one-cycle clear of the sticky `OVERRUN` flag.
- `RX_DATA`, output, `DATA_BITS`: data at the FIFO head. Zero-extended; shows 0 when the FIFO is empty.
- `RX_PE`, output, 1: parity-error tag of the head entry.
- `RX_FE`, output, 1: framing-error tag of the head entry.
- `RXRDY`, output, 1: FIFO is non-empty.
- `FFULL`, output, 1: FIFO is full.
- `OVERRUN`, output, 1: sticky flag; a character was lost.

## Operation
- `RXD` passes through a 2-flop synchroniser; all decisions use the synchronised value.
- The state machine has five states: IDLE, START, DATA, PARITY, STOP. A 4-bit tick counter advances only on `BAUD_X16`.
- IDLE: stay until the synchronised `RXD` is low on a tick. Then go to START with count = 0.
- START: on the 8th tick (mid-bit), sample the line.
  - High means a false start; return to IDLE.
  - Low means go to DATA with bit index 0.
- DATA: sample every 16 ticks and shift bits in LSB first.
  - After bit `DATA_BITS-1`, go to PARITY if `PARITY_EN`, else to STOP.
- PARITY: sample one bit. PE = (XOR of data bits XOR parity bit) != `PARITY_ODD`.
- STOP: sample one bit. FE = sample is low. Push {FE, PE, data} into the FIFO.
  - If FE is 1, wait in STOP until the line is high (break/low-line hold), then go to IDLE. Otherwise go to IDLE directly.
- Push rules:
  - FIFO not full: the entry is written.
  - FIFO full and no pop in the same cycle: the character is discarded and `OVERRUN` is set.
  - FIFO full with `RD_STB` in the same cycle: the pop and the push both complete. No overrun.
- `RD_STB` when the FIFO is empty is ignored. Pointers and flags do not change.
- `CLR_ERR` clears `OVERRUN`. If an overrun occurs in the same cycle as `CLR_ERR`, set wins.
- `RX_EN` falling mid-character aborts the character: no push, and the state goes to IDLE.
- `PARITY_EN`, `PARITY_ODD` and `RX_EN` are sampled live. Software changes them only while idle.
- Reset state: IDLE, FIFO empty, `OVERRUN`=0, `RXRDY`=0, `FFULL`=0, `RX_DATA`=0, `RX_PE`=0, `RX_FE`=0, synchroniser flops=1.

## Timing
- Synchroniser latency is 2 `CLK` cycles from `RXD` to the state machine.
- Counting from the tick that detects the start edge as tick 0:
  - Start is sampled at tick 8.
  - Data bit i is sampled at tick 8+16(i+1).
  - Parity is sampled at tick 8+16(`DATA_BITS`+1).
  - Stop is sampled 16 ticks after the last data or parity sample.
- The push is registered on the `CLK` edge of the stop-sample tick. `RXRDY` and the head outputs are valid on the next cycle.
- Pop: the cycle after `RD_STB`, the outputs show the next entry, or zeros with `RXRDY`=0.
- `FFULL` and `OVERRUN` update one cycle after the causing event.

## Structure
- Shared package `uart_pkg` holds:
  - the `rx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - the `rx_entry_t` struct {fe, pe, data[7:0]};
  - the constant `OVERSAMPLE` = 16.
- One sub-module, `uart_rx_fifo`: a synchronous FIFO of `rx_entry_t` parametrised by `FIFO_DEPTH`, with push/pop, full/empty and simultaneous push+pop-when-full support.
- A future `uart_tx_channel` reuses `uart_pkg`.

## Test plan
- 8N1, `BAUD_X16` every 4 `CLK`s, send 0xA5 → `RXRDY`=1 with `RX_DATA`=0xA5, PE=0, FE=0. After `RD_STB`, `RXRDY`=0.
- `DATA_BITS`=7, `PARITY_EN`=1, odd parity, send 0x41 with parity bit 1 → PE=0. Repeat with parity bit 0 → PE=1, and the data is still 0x41.
- Low pulse of 4 ticks on idle `RXD` → no push, and the state returns to IDLE.
- Send 0x55 with stop bit held low for 3 bit times → entry 0x55 with FE=1. Exactly one push; the next character is received normally once the line has been high.
- `FIFO_DEPTH`=4, send 5 characters 0x01..0x05 with no reads → `FFULL`=1, `OVERRUN`=1, and reads return 0x01..0x04. `CLR_ERR` clears `OVERRUN`.
- FIFO full and `RD_STB` asserted on the push cycle of a 5th character → `OVERRUN` stays 0, and the FIFO holds 0x02..0x05. Separately, assert `_RESET` mid-character → all outputs return to their reset values immediately.
